// File: rtl/alu_pkg.sv
// alu_pkg: command codes, timeout length and state/operand-need encodings for the ALU operand collector
package alu_pkg;
    localparam logic [3:0] ARITH_ADD     = 4'd0;
    localparam logic [3:0] ARITH_SUB     = 4'd1;
    localparam logic [3:0] ARITH_ADD_CIN = 4'd2;
    localparam logic [3:0] ARITH_SUB_CIN = 4'd3;
    localparam logic [3:0] ARITH_INC_A   = 4'd4;
    localparam logic [3:0] ARITH_DEC_A   = 4'd5;
    localparam logic [3:0] ARITH_INC_B   = 4'd6;
    localparam logic [3:0] ARITH_DEC_B   = 4'd7;
    localparam logic [3:0] ARITH_CMP     = 4'd8;
    localparam logic [3:0] ARITH_MUL_INC = 4'd9;
    localparam logic [3:0] ARITH_MUL_SHL = 4'd10;
    localparam logic [3:0] LOGIC_AND     = 4'd0;
    localparam logic [3:0] LOGIC_NAND    = 4'd1;
    localparam logic [3:0] LOGIC_OR      = 4'd2;
    localparam logic [3:0] LOGIC_NOR     = 4'd3;
    localparam logic [3:0] LOGIC_XOR     = 4'd4;
    localparam logic [3:0] LOGIC_XNOR    = 4'd5;
    localparam logic [3:0] LOGIC_NOT_A   = 4'd6;
    localparam logic [3:0] LOGIC_NOT_B   = 4'd7;
    localparam logic [3:0] LOGIC_SHR1_A  = 4'd8;
    localparam logic [3:0] LOGIC_SHL1_A  = 4'd9;
    localparam logic [3:0] LOGIC_SHR1_B  = 4'd10;
    localparam logic [3:0] LOGIC_SHL1_B  = 4'd11;
    localparam logic [3:0] LOGIC_ROL     = 4'd12;
    localparam logic [3:0] LOGIC_ROR     = 4'd13;
    localparam int ALU_WAIT_CYCLES = 16;
    typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B} opc_state_t;
    typedef enum logic [1:0] {NONE_ILLEGAL, A, B, AB} opnd_need_t;
endpackage

// File: rtl/alu_cmd_decode.sv
// alu_cmd_decode: maps mode/cmd to the operands the command consumes
module alu_cmd_decode
    import alu_pkg::*;
(
    input  logic       mode,
    input  logic [3:0] cmd,
    output opnd_need_t need
);
    // arithmetic codes above MUL_SHL and logical codes above ROR are illegal
    always_comb
        need = mode ? ((cmd inside {ARITH_INC_A, ARITH_DEC_A}) ? A :
                       (cmd inside {ARITH_INC_B, ARITH_DEC_B}) ? B :
                       (cmd <= ARITH_MUL_SHL) ? AB : NONE_ILLEGAL)
                    : ((cmd inside {LOGIC_NOT_A, LOGIC_SHR1_A, LOGIC_SHL1_A}) ? A :
                       (cmd inside {LOGIC_NOT_B, LOGIC_SHR1_B, LOGIC_SHL1_B}) ? B :
                       (cmd <= LOGIC_ROR) ? AB : NONE_ILLEGAL);
endmodule

// File: rtl/alu_operand_collector.sv
// alu_operand_collector: aligns split opa/opb arrivals into one registered command beat; ALU_OPC_ROTATE_CHK_EN enables the rotate range check
module alu_operand_collector
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    input  logic         cin,
    input  logic         mode,
    input  logic [3:0]   cmd,
    input  logic [1:0]   inp_valid,
    output logic         op_valid,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic [3:0]   op_cmd,
    output logic         op_mode,
    output logic         op_cin,
    output logic         err
);
    opc_state_t   state;
    opnd_need_t   need;
    logic [3:0]   cnt;
    logic [W-1:0] h_a, h_b;
    logic [3:0]   h_cmd;
    logic         h_mode, h_cin;
    logic [W-1:0] a_sel, b_sel;
    logic [3:0]   cmd_sel;
    logic         mode_sel, cin_sel;
    logic         fire, illegal, timeout, rot_bad;

    alu_cmd_decode u_dec (
        .mode(mode),
        .cmd (cmd),
        .need(need)
    );

    // pick live inputs or held partial values, and decide issue/error for this cycle
    always_comb begin
        a_sel    = (state == WAIT_B) ? h_a : opa;
        b_sel    = (state == WAIT_A) ? h_b : opb;
        cmd_sel  = (state == IDLE) ? cmd : h_cmd;
        mode_sel = (state == IDLE) ? mode : h_mode;
        cin_sel  = (state == IDLE) ? cin : h_cin;
        fire     = (state == IDLE) ? ((need == AB) ? &inp_valid :
                                      (need == A) ? inp_valid[0] :
                                      (need == B) ? inp_valid[1] : 1'b0)
                 : (state == WAIT_B) ? inp_valid[1] : inp_valid[0];
        illegal  = (state == IDLE) && (need == NONE_ILLEGAL) && (|inp_valid);
        timeout  = (state != IDLE) && !fire && (cnt == 4'(ALU_WAIT_CYCLES - 2));
`ifdef ALU_OPC_ROTATE_CHK_EN
        rot_bad  = !mode_sel && (cmd_sel inside {LOGIC_ROL, LOGIC_ROR}) && (|b_sel[W-1:$clog2(W)]);
`else
        rot_bad  = 1'b0;
`endif
    end

    // collector FSM: capture partials, count wait cycles, register the issue beat
    always_ff @(posedge clk)
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_valid <= 1'b0;
            err      <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_cmd   <= '0;
            op_mode  <= 1'b0;
            op_cin   <= 1'b0;
            h_a      <= '0;
            h_b      <= '0;
            h_cmd    <= '0;
            h_mode   <= 1'b0;
            h_cin    <= 1'b0;
        end else if (ce) begin
            op_valid <= fire && !rot_bad;
            err      <= illegal || timeout || (fire && rot_bad);
            if (fire && !rot_bad) begin
                op_a    <= a_sel;
                op_b    <= b_sel;
                op_cmd  <= cmd_sel;
                op_mode <= mode_sel;
                op_cin  <= cin_sel;
            end
            if (state == IDLE) begin
                cnt    <= '0;
                h_a    <= opa;
                h_b    <= opb;
                h_cmd  <= cmd;
                h_mode <= mode;
                h_cin  <= cin;
                state  <= (need == AB && inp_valid == 2'b01) ? WAIT_B :
                          (need == AB && inp_valid == 2'b10) ? WAIT_A : IDLE;
            end else begin
                cnt   <= cnt + 4'd1;
                state <= (fire || timeout) ? IDLE : state;
            end
        end
endmodule

// File: doc/alu_operand_collector.md
# alu_operand_collector

Input-side receiver for the ALU operand protocol. Accepts `opa`/`opb` that may arrive in separate cycles, qualified by `inp_valid`, and holds a partial command for up to 16 cycles. It then issues one aligned, registered command beat to the ALU core, or flags `err` on timeout or an illegal command. It sits between the stimulus/bus side and the ALU datapath, gated by the clock-enable `ce`.

## Interface
Parameters:
- `W`, 8, operand width; must be a power of two, ≥ 4.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ce`  in  1  clock enable; when low, all state, counters and outputs hold.
- `opa`, `opb`  in  W each  operands.
- `cin`  in  1  carry in.
- `mode`  in  1  1 = arithmetic, 0 = logical.
- `cmd`  in  4  command.
- `inp_valid`  in  2  bit0 = `opa` valid, bit1 = `opb` valid.
- `op_valid`  out  1  one-cycle pulse: aligned command ready.
- `op_a`, `op_b`  out  W each  aligned operands.
- `op_cmd`  out  4  aligned command.
- `op_mode`, `op_cin`  out  1 each  aligned mode and carry in.
- `err`  out  1  one-cycle pulse: timeout, illegal command or rotate range error.

## Operation
- Operand requirement by command (from `alu_cmd_decode`):
  - mode 1, cmd 4,5: A only.
  - mode 1, cmd 6,7: B only.
  - mode 1, cmd 0–3, 8–10: both operands.
  - mode 1, cmd 11–15: illegal.
  - mode 0, cmd 6,8,9: A only.
  - mode 0, cmd 7,10,11: B only.
  - mode 0, cmd 0–5, 12, 13: both operands.
  - mode 0, cmd 14,15: illegal.
- States are IDLE, WAIT_A and WAIT_B. All transitions require `ce=1`.
- IDLE:
  - `inp_valid=00`: stay in IDLE.
  - `inp_valid` supplies every required operand: capture and issue.
  - Two-operand cmd with `inp_valid=01`: capture `opa`, `cmd`, `mode`, `cin`, clear the counter, go to WAIT_B.
  - Two-operand cmd with `inp_valid=10`: mirror of the above, go to WAIT_A.
  - Single-operand cmd whose operand is absent: ignored, no error.
- WAIT_B:
  - `inp_valid[1]=1`: capture `opb`, issue with the held `opa`/`cmd`/`mode`/`cin`, return to IDLE. Any new `opa`, `cmd`, `mode` or `cin` on that cycle is ignored.
  - Otherwise: increment the counter.
- WAIT_A: symmetric to WAIT_B.
- Timeout: the partial capture is at cycle T. The missing operand is accepted in T+1..T+15. If it has not arrived, the block raises `err` at T+16, does not issue, and returns to IDLE.
- Illegal command in IDLE (any nonzero `inp_valid`): `err` pulse, no issue.
- Rotate check (mode 0, cmd 12/13), applied at issue time: if `opb[W-1:$clog2(W)]` ≠ 0, raise `err` instead of `op_valid`.
- Outputs `op_*` change only on issue and hold between issues.

## Timing
- Reset values: `op_valid=0`, `err=0`, `op_a=0`, `op_b=0`, `op_cmd=0`, `op_mode=0`, `op_cin=0`, state IDLE, counter 0.
- Latency: an issue decision on cycle N drives `op_valid` (or `err`) high on cycle N+1 for exactly one cycle (registered).
- `op_valid` and `err` are never high together.
- `ce` low mid-wait freezes the counter; stalled cycles do not count toward the 16.
- `rst` mid-wait discards the partial command; no `err` or `op_valid` is raised.
- Back-to-back full commands are accepted every cycle, giving one issue per cycle.

## Configuration
- `ALU_OPC_ROTATE_CHK_EN` defined: rotate range check active as described in Operation.
- Not defined: cmd 12/13 always issue with `op_valid`, regardless of `opb` upper bits.

## Structure
- Package `alu_pkg`:
  - `cmd` constants per mode.
  - `ALU_WAIT_CYCLES = 16`.
  - State enum `opc_state_t`.
  - Operand-need encoding `opnd_need_t` (NONE_ILLEGAL, A, B, AB).
- Sub-module `alu_cmd_decode`: combinational; maps `mode`/`cmd` to `opnd_need_t`.

## Test plan
- mode 1, cmd 0, `inp_valid=11`, opa=8'h12, opb=8'h34 -> next cycle `op_valid=1`, `op_a=8'h12`, `op_b=8'h34`, `op_cmd=0`.
- mode 1, cmd 0, `inp_valid=01` opa=8'hAA at T, `inp_valid=10` opb=8'h55 at T+15 -> `op_valid` at T+16 with `op_a=8'hAA`, `op_b=8'h55`, `err=0`.
- mode 0, cmd 1, `inp_valid=10` at T, then `inp_valid=00` for 15 cycles -> `err` pulse at T+16, no `op_valid`; `inp_valid=11` at T+17 issues normally.
- Partial capture at T, `ce=0` for cycles T+3..T+7 -> `err` delayed to T+21.
- mode 0, cmd 12, `inp_valid=11`, opb=8'h13 -> `err` with the macro defined; `op_valid` with `op_b=8'h13` without it.
- mode 1, cmd 14, `inp_valid=11` -> `err` pulse. Separately, `rst` asserted while in WAIT_B -> all outputs 0 and no `err` afterwards.
